cmd_interp_parser: RTL and testbench

CMD_INTERP_PARSER -- requirements
Module: cmd_interp_parser

---
 rtl/cmd_interp_parser.sv | 137 +++++++++++++
 tb/tb_cmd_interp_parser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_interp_parser.sv
// cmd_interp_parser: ASCII command parser for "A op B =" calculator commands (A, B = 1-2 digits).
// Latency: every strobe appears the cycle after its byte is sampled; exec comes EXEC_DELAY cycles after '='.
// Backpressure: none; bytes arriving while waiting to issue exec are dropped, all others are processed.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_data/valid   ASCII byte and its one-cycle strobe from the UART receiver
//   digit           binary value of the last accepted digit (drives operand register data)
//   load1_a/load2_a first/second digit load strobes for operand A
//   load1_b/load2_b first/second digit load strobes for operand B
//   op              operator code: '+'=00 '-'=01 '*'=10 '/'=11
//   exec/err/clr    one-cycle strobes: start calculation / syntax error / clear
//   busy            high whenever a command is in progress
module cmd_interp_parser #(
  parameter int EXEC_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] digit,
  output logic       load1_a,
  output logic       load2_a,
  output logic       load1_b,
  output logic       load2_b,
  output logic [1:0] op,
  output logic       exec,
  output logic       err,
  output logic       clr,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, A1, A2, OPR, B1, B2, WAIT} state_t;

  // Wait counter holds the number of extra WAIT cycles still to spend before exec.
  localparam int CW = (EXEC_DELAY > 2) ? $clog2(EXEC_DELAY) : 1;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Byte classification.
  logic       is_digit;
  logic       is_op;
  logic       is_eq;
  logic       is_space;
  logic       is_clr;
  logic [1:0] op_code;

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_eq    = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    is_space = (rx_data == 8'h20);
    is_clr   = (rx_data == 8'h43) || (rx_data == 8'h63);
    is_op    = 1'b1;
    op_code  = 2'b00;
    case (rx_data)
      8'h2B:   op_code = 2'b00;
      8'h2D:   op_code = 2'b01;
      8'h2A:   op_code = 2'b10;
      8'h2F:   op_code = 2'b11;
      default: is_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      digit    <= 8'd0;
      op       <= 2'b00;
      load1_a  <= 1'b0;
      load2_a  <= 1'b0;
      load1_b  <= 1'b0;
      load2_b  <= 1'b0;
      exec     <= 1'b0;
      err      <= 1'b0;
      clr      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      load1_a <= 1'b0;
      load2_a <= 1'b0;
      load1_b <= 1'b0;
      load2_b <= 1'b0;
      exec    <= 1'b0;
      err     <= 1'b0;
      clr     <= 1'b0;

      if (state == WAIT) begin
        // Input is ignored here; only the settle countdown runs.
        if (wait_cnt == '0) begin
          exec  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end else if (rx_valid && !is_space) begin
        if (is_clr) begin
          clr   <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end else if (is_digit && (state == IDLE || state == A1 ||
                                  state == OPR  || state == B1)) begin
          digit <= rx_data - 8'h30;
          busy  <= 1'b1;
          case (state)
            IDLE: begin state <= A1; load1_a <= 1'b1; end
            A1:   begin state <= A2; load2_a <= 1'b1; end
            OPR:  begin state <= B1; load1_b <= 1'b1; end
            default: begin state <= B2; load2_b <= 1'b1; end
          endcase
        end else if (is_op && (state == A1 || state == A2)) begin
          op    <= op_code;
          state <= OPR;
          busy  <= 1'b1;
        end else if (is_eq && (state == B1 || state == B2)) begin
          if (EXEC_DELAY <= 1) begin
            exec  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= WAIT;
            wait_cnt <= CW'(EXEC_DELAY - 2);
            busy     <= 1'b1;
          end
        end else begin
          // Third digit, misplaced operator/terminator or unknown byte.
          err   <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_interp_parser.sv
module tb_cmd_interp_parser;

  localparam int EXEC_DELAY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] digit;
  logic       load1_a, load2_a, load1_b, load2_b;
  logic [1:0] op;
  logic       exec, err, clr, busy;

  cmd_interp_parser #(.EXEC_DELAY(EXEC_DELAY)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .digit(digit), .load1_a(load1_a), .load2_a(load2_a),
    .load1_b(load1_b), .load2_b(load2_b), .op(op),
    .exec(exec), .err(err), .clr(clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: counts of digits collected for A and B, whether an
  // operator was seen, and cycles remaining until exec.
  int         na, nb, remain;
  bit         has_op, waiting;
  logic [7:0] m_digit;
  logic [1:0] m_op;
  logic [6:0] m_str; // {l1a,l2a,l1b,l2b,exec,err,clr}
  logic       m_busy;

  // Downstream operand registers rebuilt from the DUT's strobes.
  int opa, opb, exec_cnt, err_cnt, clr_cnt;

  task automatic abort_cmd();
    na = 0; nb = 0; has_op = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    m_str = '0;
    if (r) begin
      abort_cmd(); waiting = 0; m_digit = 8'd0; m_op = 2'b00;
    end else if (waiting) begin
      remain--;
      if (remain == 0) begin m_str[2] = 1'b1; waiting = 0; end
    end else if (v && d != 8'h20) begin
      if (d == "C" || d == "c") begin
        m_str[0] = 1'b1; abort_cmd();
      end else if (d >= "0" && d <= "9") begin
        if (!has_op && na < 2) begin
          na++; m_digit = d - 8'h30; m_str[na == 1 ? 6 : 5] = 1'b1;
        end else if (has_op && nb < 2) begin
          nb++; m_digit = d - 8'h30; m_str[nb == 1 ? 4 : 3] = 1'b1;
        end else begin
          m_str[1] = 1'b1; abort_cmd();
        end
      end else if (d == "+" || d == "-" || d == "*" || d == "/") begin
        if (!has_op && na > 0) begin
          has_op = 1;
          m_op = (d == "+") ? 2'd0 : (d == "-") ? 2'd1 : (d == "*") ? 2'd2 : 2'd3;
        end else begin
          m_str[1] = 1'b1; abort_cmd();
        end
      end else if (d == "=" || d == 8'h0D) begin
        if (has_op && nb > 0) begin
          abort_cmd(); waiting = 1; remain = EXEC_DELAY - 1;
          if (remain == 0) begin m_str[2] = 1'b1; waiting = 0; end
        end else begin
          m_str[1] = 1'b1; abort_cmd();
        end
      end else begin
        m_str[1] = 1'b1; abort_cmd();
      end
    end
    m_busy = waiting || (na > 0);
  endtask

  task automatic check_outputs(input string tag);
    logic [17:0] obs, expv;
    logic [6:0]  str;
    str  = {load1_a, load2_a, load1_b, load2_b, exec, err, clr};
    obs  = {digit, op, str, busy};
    expv = {m_digit, m_op, m_str, m_busy};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs={digit,op,str,busy}=%h exp=%h", tag, obs, expv);
    end
    checks++;
    assert ($countones(str) <= 1) else begin
      errors++;
      $error("FAIL %s_onehot obs=%b exp=at_most_one", tag, str);
    end
    if (load1_a) opa = digit;
    if (load2_a) opa = opa * 10 + int'(digit);
    if (load1_b) opb = digit;
    if (load2_b) opb = opb * 10 + int'(digit);
    if (exec) exec_cnt++;
    if (err)  err_cnt++;
    if (clr)  clr_cnt++;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input string tag);
    @(negedge clk);
    rx_valid = v; rx_data = d; rst = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    check_outputs(tag);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    cyc(1'b1, d, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, tag);
  endtask

  task automatic expect_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  logic [7:0] alphabet [20];

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    abort_cmd(); waiting = 0; remain = 0; m_digit = 0; m_op = 0; m_str = 0; m_busy = 0;
    opa = 0; opb = 0; exec_cnt = 0; err_cnt = 0; clr_cnt = 0;

    // Reset state, including a byte offered during reset.
    cyc(1'b0, 8'h00, 1'b1, "reset");
    cyc(1'b1, "5", 1'b1, "reset_with_byte");
    idle(1, "post_reset");

    // 12+3=
    send("1", "a1"); send("2", "a2"); send("+", "op_add"); send("3", "b1");
    send("=", "eq"); idle(3, "exec_wait");
    expect_int("opA_12", opa, 12);
    expect_int("opB_3", opb, 3);
    expect_int("exec_once_a", exec_cnt, 1);

    // 99*99 CR
    send("9", "a1_9"); send("9", "a2_9"); send("*", "op_mul");
    send("9", "b1_9"); send("9", "b2_9"); send(8'h0D, "cr"); idle(3, "exec_wait2");
    expect_int("opA_99", opa, 99);
    expect_int("opB_99", opb, 99);
    expect_int("exec_once_b", exec_cnt, 2);

    // Third digit error.
    send("1", "d1"); send("2", "d2"); send("3", "d3_err"); idle(1, "after_err");
    expect_int("err_third_digit", err_cnt, 1);

    // Operator in IDLE, space, unknown byte, clear.
    send("+", "op_idle_err"); send("5", "a5"); send(" ", "space");
    send("-", "op_sub"); send("x", "x_err"); send("4", "a4"); send("c", "clr_lc");
    expect_int("err_count", err_cnt, 3);
    expect_int("clr_count", clr_cnt, 1);

    // 7/8= with a byte dropped during WAIT.
    send("7", "a7"); send("/", "op_div"); send("8", "b8"); send("=", "eq2");
    send("1", "drop_in_wait"); idle(2, "exec_wait3");
    expect_int("exec_once_c", exec_cnt, 3);

    // Reset in B1 and in WAIT abort silently.
    send("3", "a3"); send("+", "op_add2"); send("4", "b4");
    cyc(1'b0, 8'h00, 1'b1, "rst_in_b1"); idle(3, "no_exec");
    send("2", "a2_after_rst"); send("=", "eq_err");
    send("1", "a1w"); send("+", "opw"); send("1", "b1w"); send("=", "eqw");
    cyc(1'b0, 8'h00, 1'b1, "rst_in_wait"); idle(3, "no_exec2");
    expect_int("exec_total", exec_cnt, 3);

    // Randomized traffic against the model.
    alphabet = '{"0", "1", "2", "3", "4", "5", "6", "7", "8", "9",
                 "+", "-", "*", "/", "=", 8'h0D, " ", "C", "x", "7"};
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 2)       cyc(1'b0, 8'h00, 1'b1, "rand_rst");
      else if (k < 30) cyc(1'b0, 8'($urandom), 1'b0, "rand_idle");
      else if (k < 33) cyc(1'b1, 8'($urandom), $urandom_range(0, 3) == 0, "rand_any");
      else             cyc(1'b1, alphabet[$urandom_range(0, 19)], 1'b0, "rand_sym");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
